// File: rtl/testpattern_gen2_if.sv
// Video output bundle of testpattern_gen2: timing strobes, pixel data and the
// completed-frame counter. The generator drives the master side, the
// downstream encoder (or a bench) uses the slave side.
interface testpattern_gen2_if #(
    parameter int DW  = 8,
    parameter int FCW = 16
);
    logic           O_de;
    logic           O_hs;
    logic           O_vs;
    logic [DW-1:0]  O_data_r;
    logic [DW-1:0]  O_data_g;
    logic [DW-1:0]  O_data_b;
    logic [FCW-1:0] O_frame_cnt;

    modport master (output O_de, O_hs, O_vs, O_data_r, O_data_g, O_data_b, O_frame_cnt);
    modport slave  (input  O_de, O_hs, O_vs, O_data_r, O_data_g, O_data_b, O_frame_cnt);
endinterface

// File: rtl/testpattern_gen2.sv
// testpattern_gen2: parametrised raster timing and test-pattern source in a
// single pixel clock domain. Pattern configuration is shadowed at each frame
// start, so every frame is drawn with one consistent setting. Pixel outputs
// trail the H/V counters by exactly four clocks.
// Optional build macro TESTPATTERN_BORDER_EN: forces the outermost ring of
// active pixels to full white in every mode.
module testpattern_gen2 #(
    parameter int DW        = 8,
    parameter int CW        = 16,
    parameter int GRID_LOG2 = 5,
    parameter int FCW       = 16
) (
    input  logic          I_pxl_clk,
    input  logic          I_rst_n,
    input  logic [2:0]    I_mode,
    input  logic [CW-1:0] I_sqr_width,
    input  logic [CW-1:0] I_scroll_step,
    input  logic [DW-1:0] I_single_r,
    input  logic [DW-1:0] I_single_g,
    input  logic [DW-1:0] I_single_b,
    input  logic [CW-1:0] I_h_total,
    input  logic [CW-1:0] I_h_sync,
    input  logic [CW-1:0] I_h_bporch,
    input  logic [CW-1:0] I_h_res,
    input  logic [CW-1:0] I_v_total,
    input  logic [CW-1:0] I_v_sync,
    input  logic [CW-1:0] I_v_bporch,
    input  logic [CW-1:0] I_v_res,
    input  logic          I_hs_pol,
    input  logic          I_vs_pol,
    testpattern_gen2_if.master vid
);
    localparam int XW = CW + 2;
    localparam int GW = (CW > DW) ? CW : DW;

    logic [CW-1:0]    r_hcnt, r_vcnt;
    logic [2:0]       r_mode;
    logic [CW-1:0]    r_sw, r_step;
    logic [DW-1:0]    r_sr, r_sg, r_sb;
    logic [CW:0]      r_off;
    logic             r_started;
    logic [FCW-1:0]   r_fcnt;
    logic [CW-1:0]    r_cx, r_cy, r_bc;
    logic             r_px, r_py;
    logic [2:0]       r_bi;
    logic [CW-1:0]    r_s1_x, r_s1_y;
    logic [3:0]       r_de_p, r_hs_p, r_vs_p;
    logic [2:0][DW-1:0] r_dr, r_dg, r_db;

    logic [XW-1:0]    w_hstart, w_hend, w_vstart, w_vend, w_w2_n, w_sum;
    logic             w_hwrap, w_vwrap, w_fstart, w_xstart, w_de, w_hs_act, w_vs_act;
    logic [CW-1:0]    w_x, w_y, w_sw_n, w_step_n, w_w_n, w_w_old, w_ph0, w_bw;
    logic [CW:0]      w_off_upd, w_off_n, w_offx;
    logic [2:0]       w_mode_n;
    logic             w_par0, w_cx_wrap, w_cy_wrap, w_bc_wrap, w_grid, w_border;
    logic [GW-1:0]    w_xg;
    logic [DW-1:0]    w_pr, w_pg, w_pb;

    assign w_hstart = XW'(I_h_sync) + XW'(I_h_bporch);
    assign w_hend   = w_hstart + XW'(I_h_res);
    assign w_vstart = XW'(I_v_sync) + XW'(I_v_bporch);
    assign w_vend   = w_vstart + XW'(I_v_res);
    assign w_hwrap  = (XW'(r_hcnt) + XW'(1)) >= XW'(I_h_total);
    assign w_vwrap  = (XW'(r_vcnt) + XW'(1)) >= XW'(I_v_total);
    assign w_fstart = (r_hcnt == '0) && (r_vcnt == '0);
    assign w_xstart = XW'(r_hcnt) == w_hstart;
    assign w_de     = (XW'(r_hcnt) >= w_hstart) && (XW'(r_hcnt) < w_hend) &&
                      (XW'(r_vcnt) >= w_vstart) && (XW'(r_vcnt) < w_vend);
    assign w_hs_act = r_hcnt < I_h_sync;
    assign w_vs_act = r_vcnt < I_v_sync;
    assign w_x      = r_hcnt - w_hstart[CW-1:0];
    assign w_y      = r_vcnt - w_vstart[CW-1:0];

    // Values the shadows will hold for the pixel currently at the counters;
    // on the frame-start cycle that is the freshly sampled input.
    assign w_sw_n   = w_fstart ? I_sqr_width   : r_sw;
    assign w_step_n = w_fstart ? I_scroll_step : r_step;
    assign w_mode_n = w_fstart ? I_mode        : r_mode;
    assign w_w_n    = (w_sw_n == '0) ? CW'(1) : w_sw_n;
    assign w_w_old  = (r_sw == '0) ? CW'(1) : r_sw;
    assign w_w2_n   = XW'({w_w_n, 1'b0});
    assign w_sum    = XW'(r_off) + XW'(w_step_n);

    // Scroll offset for the next frame: wrap into [0, 2w), freeze on an
    // oversized step, restart from zero whenever the cell size changes.
    always_comb begin
        w_off_upd = r_off;
        if (w_w_n != w_w_old) begin
            w_off_upd = '0;
        end else if (XW'(w_step_n) < w_w2_n) begin
            if (w_sum >= w_w2_n) begin
                w_off_upd = (CW+1)'(w_sum - w_w2_n);
            end else begin
                w_off_upd = (CW+1)'(w_sum);
            end
        end
    end

    assign w_off_n   = w_fstart ? w_off_upd : r_off;
    assign w_offx    = (w_mode_n == 3'd4) ? w_off_n : '0;
    assign w_par0    = w_offx >= (CW+1)'(w_w_n);
    assign w_ph0     = w_par0 ? CW'(w_offx - (CW+1)'(w_w_n)) : CW'(w_offx);
    assign w_cx_wrap = (XW'(r_cx) + XW'(1)) >= XW'(w_w_n);
    assign w_cy_wrap = (XW'(r_cy) + XW'(1)) >= XW'(w_w_n);
    assign w_bw      = I_h_res >> 3;
    assign w_bc_wrap = (XW'(r_bc) + XW'(1)) >= XW'(w_bw);

    // Raster counters; >= compares let a shrunken timing value wrap at once.
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_hwrap) begin
            r_hcnt <= '0;
            r_vcnt <= w_vwrap ? '0 : r_vcnt + CW'(1);
        end else begin
            r_hcnt <= r_hcnt + CW'(1);
        end
    end

    // Frame-start bookkeeping: config shadows, scroll offset, frame counter.
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_mode    <= '0;
            r_sw      <= '0;
            r_step    <= '0;
            r_sr      <= '0;
            r_sg      <= '0;
            r_sb      <= '0;
            r_off     <= '0;
            r_started <= 1'b0;
            r_fcnt    <= '0;
        end else if (w_fstart) begin
            r_mode    <= I_mode;
            r_sw      <= I_sqr_width;
            r_step    <= I_scroll_step;
            r_sr      <= I_single_r;
            r_sg      <= I_single_g;
            r_sb      <= I_single_b;
            r_off     <= w_off_upd;
            r_started <= 1'b1;
            if (r_started) begin
                r_fcnt <= r_fcnt + FCW'(1);
            end
        end
    end

    // Divider-free cell trackers: checker phase/parity along x and y and the
    // colour-bar index, each valid for the pixel in the first pipeline stage.
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_cx <= '0;
            r_px <= 1'b0;
            r_cy <= '0;
            r_py <= 1'b0;
            r_bc <= '0;
            r_bi <= '0;
        end else begin
            if (w_xstart) begin
                r_cx <= w_ph0;
                r_px <= w_par0;
                r_bc <= '0;
                r_bi <= '0;
            end else begin
                if (w_cx_wrap) begin
                    r_cx <= '0;
                    r_px <= ~r_px;
                end else begin
                    r_cx <= r_cx + CW'(1);
                end
                if (w_bc_wrap) begin
                    r_bc <= '0;
                    r_bi <= (r_bi == 3'd7) ? 3'd7 : r_bi + 3'd1;
                end else begin
                    r_bc <= r_bc + CW'(1);
                end
            end
            if (r_hcnt == '0) begin
                if (XW'(r_vcnt) == w_vstart) begin
                    r_cy <= '0;
                    r_py <= 1'b0;
                end else if (w_cy_wrap) begin
                    r_cy <= '0;
                    r_py <= ~r_py;
                end else begin
                    r_cy <= r_cy + CW'(1);
                end
            end
        end
    end

    assign w_xg   = GW'(r_s1_x);
    assign w_grid = (r_s1_x[GRID_LOG2-1:0] == '0) || (r_s1_y[GRID_LOG2-1:0] == '0) ||
                    (r_s1_x == I_h_res - CW'(1)) || (r_s1_y == I_v_res - CW'(1));
`ifdef TESTPATTERN_BORDER_EN
    assign w_border = (r_s1_x == '0) || (r_s1_y == '0) ||
                      (r_s1_x == I_h_res - CW'(1)) || (r_s1_y == I_v_res - CW'(1));
`else
    assign w_border = 1'b0;
`endif

    // Pixel colour for the first-stage pixel; black outside the active area.
    always_comb begin
        w_pr = '0;
        w_pg = '0;
        w_pb = '0;
        if (r_de_p[0]) begin
            case (r_mode)
                3'd0: begin
                    w_pr = {DW{~r_bi[1]}};
                    w_pg = {DW{~r_bi[2]}};
                    w_pb = {DW{~r_bi[0]}};
                end
                3'd1: w_pr = w_grid ? '1 : '0;
                3'd2: begin
                    w_pr = w_xg[DW-1:0];
                    w_pg = w_xg[DW-1:0];
                    w_pb = w_xg[DW-1:0];
                end
                3'd3, 3'd4: begin
                    w_pr = (r_px ^ r_py) ? '0 : '1;
                    w_pg = (r_px ^ r_py) ? '0 : '1;
                    w_pb = (r_px ^ r_py) ? '0 : '1;
                end
                3'd7: begin
                    w_pr = r_sr;
                    w_pg = r_sg;
                    w_pb = r_sb;
                end
                default: w_pb = '1;
            endcase
            if (w_border) begin
                w_pr = '1;
                w_pg = '1;
                w_pb = '1;
            end
        end
    end

    // Four-stage delay line keeping strobes and data aligned.
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_s1_x <= '0;
            r_s1_y <= '0;
            r_de_p <= '0;
            r_hs_p <= '0;
            r_vs_p <= '0;
            r_dr   <= '0;
            r_dg   <= '0;
            r_db   <= '0;
        end else begin
            r_s1_x <= w_x;
            r_s1_y <= w_y;
            r_de_p <= {r_de_p[2:0], w_de};
            r_hs_p <= {r_hs_p[2:0], w_hs_act};
            r_vs_p <= {r_vs_p[2:0], w_vs_act};
            r_dr   <= {r_dr[1:0], w_pr};
            r_dg   <= {r_dg[1:0], w_pg};
            r_db   <= {r_db[1:0], w_pb};
        end
    end

    assign vid.O_de        = r_de_p[3];
    assign vid.O_hs        = I_hs_pol ? r_hs_p[3] : ~r_hs_p[3];
    assign vid.O_vs        = I_vs_pol ? r_vs_p[3] : ~r_vs_p[3];
    assign vid.O_data_r    = r_dr[2];
    assign vid.O_data_g    = r_dg[2];
    assign vid.O_data_b    = r_db[2];
    assign vid.O_frame_cnt = r_fcnt;
endmodule
